// File: rtl/ofdm_qam_mapper_pkg.sv
// Shared constants for the OFDM constellation mapper: mode codes, bits-per-subcarrier
// table and power-normalised step sizes as a function of the output width.
package ofdm_qam_mapper_pkg;

    typedef enum logic [1:0] {
        MODE_BPSK  = 2'd0,
        MODE_QPSK  = 2'd1,
        MODE_QAM16 = 2'd2,
        MODE_QAM64 = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } map_state_e;

    localparam int unsigned BCNT_W = 3;
    localparam int unsigned SR_W   = 6;

    // 1/sqrt(N) normalisation factors in Q0.20
    localparam longint unsigned K20_QPSK  = 64'd741455;
    localparam longint unsigned K20_QAM16 = 64'd331589;
    localparam longint unsigned K20_QAM64 = 64'd161799;

    function automatic logic [BCNT_W-1:0] bpsc_of(input mode_e m);
        logic [BCNT_W-1:0] r;
        case (m)
            MODE_BPSK:  r = BCNT_W'(1);
            MODE_QPSK:  r = BCNT_W'(2);
            MODE_QAM16: r = BCNT_W'(4);
            default:    r = BCNT_W'(6);
        endcase
        return r;
    endfunction

    // round(2^(dw-2) * K_mod), computed in Q0.20 with half-LSB rounding
    function automatic int unsigned step_of(input int unsigned dw, input mode_e m);
        longint unsigned unit;
        longint unsigned k;
        unit = 64'd1 << (dw - 2);
        case (m)
            MODE_BPSK:  k = 64'd1 << 20;
            MODE_QPSK:  k = K20_QPSK;
            MODE_QAM16: k = K20_QAM16;
            default:    k = K20_QAM64;
        endcase
        return 32'((unit * k + (64'd1 << 19)) >> 20);
    endfunction

endpackage

// File: rtl/ofdm_qam_level_lut.sv
// Gray-coded 802.11a amplitude level lookup for one axis; bits[2] is the first-received bit.
module ofdm_qam_level_lut
    import ofdm_qam_mapper_pkg::*;
(
    input  mode_e              cur_mode,
    input  logic [2:0]         bits,
    output logic signed [3:0]  level
);

    always_comb begin
        level = 4'sd0;
        case (cur_mode)
            MODE_BPSK, MODE_QPSK: begin
                level = bits[2] ? 4'sd1 : -4'sd1;
            end
            MODE_QAM16: begin
                case (bits[2:1])
                    2'b00:   level = -4'sd3;
                    2'b01:   level = -4'sd1;
                    2'b11:   level =  4'sd1;
                    default: level =  4'sd3;
                endcase
            end
            default: begin
                case (bits)
                    3'b000:  level = -4'sd7;
                    3'b001:  level = -4'sd5;
                    3'b011:  level = -4'sd3;
                    3'b010:  level = -4'sd1;
                    3'b110:  level =  4'sd1;
                    3'b111:  level =  4'sd3;
                    3'b101:  level =  4'sd5;
                    default: level =  4'sd7;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/ofdm_qam_mapper.sv
// Bit-serial constellation mapper: groups BPSC input bits, maps them to scaled I/Q
// samples one cycle after the group completes, and tags each with its subcarrier index.
module ofdm_qam_mapper
    import ofdm_qam_mapper_pkg::*;
#(
    parameter int unsigned DW   = 12,
    parameter int unsigned NSC  = 48,
    parameter int unsigned IDXW = 6
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             di,
    input  logic             di_vld,
    output logic [DW-1:0]    do_re,
    output logic [DW-1:0]    do_im,
    output logic             do_vld,
    output logic [IDXW-1:0]  do_idx,
    output logic             do_sym_end
);

    localparam int unsigned PW = DW + 4;
    localparam logic signed [PW-1:0] STEP_BPSK  = PW'(step_of(DW, MODE_BPSK));
    localparam logic signed [PW-1:0] STEP_QPSK  = PW'(step_of(DW, MODE_QPSK));
    localparam logic signed [PW-1:0] STEP_QAM16 = PW'(step_of(DW, MODE_QAM16));
    localparam logic signed [PW-1:0] STEP_QAM64 = PW'(step_of(DW, MODE_QAM64));
    localparam logic [IDXW-1:0]      IDX_LAST   = IDXW'(NSC - 1);

    map_state_e         state, state_nxt;
    logic [BCNT_W-1:0]  bcnt, bcnt_nxt;
    mode_e              cur_mode;
    mode_e              eff_mode_c;
    logic               grp_last_c;
    logic [SR_W-1:0]    sr;
    logic               grp_done;
    logic [IDXW-1:0]    scnt;

    logic [2:0]         bits_i_c, bits_q_c;
    logic signed [3:0]  lut_i_c, lut_q_c, lvl_q_c;
    logic signed [PW-1:0] step_c;

    // Mode is taken from the port only at group start, otherwise from the latched copy
    always_comb begin
        state_nxt  = state;
        bcnt_nxt   = bcnt;
        eff_mode_c = (state == ST_IDLE) ? mode_e'(mode) : cur_mode;
        grp_last_c = (bcnt == bpsc_of(eff_mode_c) - BCNT_W'(1));
        if (di_vld) begin
            if (grp_last_c) begin
                state_nxt = ST_IDLE;
                bcnt_nxt  = '0;
            end else begin
                state_nxt = ST_COLLECT;
                bcnt_nxt  = bcnt + BCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            bcnt     <= '0;
            cur_mode <= MODE_BPSK;
            sr       <= '0;
            grp_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            bcnt     <= bcnt_nxt;
            grp_done <= di_vld && grp_last_c;
            if (di_vld) begin
                sr[bcnt] <= di;
                if (state == ST_IDLE)
                    cur_mode <= mode_e'(mode);
            end
        end
    end

    // Per-axis bit fields, first-received bit in the MSB position of the LUT input
    always_comb begin
        bits_i_c = 3'b000;
        bits_q_c = 3'b000;
        step_c   = STEP_BPSK;
        case (cur_mode)
            MODE_BPSK: begin
                bits_i_c = {sr[0], 2'b00};
                step_c   = STEP_BPSK;
            end
            MODE_QPSK: begin
                bits_i_c = {sr[0], 2'b00};
                bits_q_c = {sr[1], 2'b00};
                step_c   = STEP_QPSK;
            end
            MODE_QAM16: begin
                bits_i_c = {sr[0], sr[1], 1'b0};
                bits_q_c = {sr[2], sr[3], 1'b0};
                step_c   = STEP_QAM16;
            end
            default: begin
                bits_i_c = {sr[0], sr[1], sr[2]};
                bits_q_c = {sr[3], sr[4], sr[5]};
                step_c   = STEP_QAM64;
            end
        endcase
        lvl_q_c = (cur_mode == MODE_BPSK) ? 4'sd0 : lut_q_c;
    end

    ofdm_qam_level_lut u_lut_i (
        .cur_mode (cur_mode),
        .bits     (bits_i_c),
        .level    (lut_i_c)
    );

    ofdm_qam_level_lut u_lut_q (
        .cur_mode (cur_mode),
        .bits     (bits_q_c),
        .level    (lut_q_c)
    );

    // Output register: product at PW bits, truncated to DW
    always_ff @(posedge clk) begin
        if (rst) begin
            do_re      <= '0;
            do_im      <= '0;
            do_vld     <= 1'b0;
            do_idx     <= '0;
            do_sym_end <= 1'b0;
            scnt       <= '0;
        end else begin
            do_vld     <= grp_done;
            do_sym_end <= grp_done && (scnt == IDX_LAST);
            if (grp_done) begin
                do_re  <= DW'(PW'(lut_i_c) * step_c);
                do_im  <= DW'(PW'(lvl_q_c) * step_c);
                do_idx <= scnt;
                scnt   <= (scnt == IDX_LAST) ? '0 : scnt + IDXW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ofdm_qam_mapper.sv
// Scoreboard bench for ofdm_qam_mapper: directed groups push expected samples,
// a negedge monitor pops and compares every do_vld.
module tb_ofdm_qam_mapper;

    localparam int unsigned DW   = 12;
    localparam int unsigned NSC  = 48;
    localparam int unsigned IDXW = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      mode;
    logic            di;
    logic            di_vld;
    logic [DW-1:0]   do_re;
    logic [DW-1:0]   do_im;
    logic            do_vld;
    logic [IDXW-1:0] do_idx;
    logic            do_sym_end;

    typedef struct packed {
        logic [DW-1:0]   re;
        logic [DW-1:0]   im;
        logic [IDXW-1:0] idx;
        logic            sym_end;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_idx = 0;

    always #5 clk = ~clk;

    ofdm_qam_mapper #(.DW(DW), .NSC(NSC), .IDXW(IDXW)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .di         (di),
        .di_vld     (di_vld),
        .do_re      (do_re),
        .do_im      (do_im),
        .do_vld     (do_vld),
        .do_idx     (do_idx),
        .do_sym_end (do_sym_end)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_exp(input logic [DW-1:0] re, input logic [DW-1:0] im);
        exp_t e;
        e.re      = re;
        e.im      = im;
        e.idx     = IDXW'(exp_idx);
        e.sym_end = (exp_idx == NSC - 1);
        q.push_back(e);
        exp_idx = (exp_idx == NSC - 1) ? 0 : exp_idx + 1;
    endtask

    task automatic send_bit(input logic b, input int gap);
        di     = b;
        di_vld = 1'b1;
        @(posedge clk); #1;
        di_vld = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_idx = 0;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (q.size() != 0 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        check(name, 32'(q.size()), 32'd0);
    endtask

    // Monitor: every valid sample must match the head of the scoreboard
    always @(negedge clk) begin
        if (do_vld) begin
            if (q.size() == 0) begin
                check("unexpected_vld", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("do_re",      32'(do_re),      32'(e.re));
                check("do_im",      32'(do_im),      32'(e.im));
                check("do_idx",     32'(do_idx),     32'(e.idx));
                check("do_sym_end", 32'(do_sym_end), 32'(e.sym_end));
            end
        end else begin
            if (do_sym_end !== 1'b0)
                check("sym_end_without_vld", 32'(do_sym_end), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        mode   = 2'd0;
        di     = 1'b0;
        di_vld = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(negedge clk);
        check("rst_vld",     32'(do_vld),     32'd0);
        check("rst_re",      32'(do_re),      32'd0);
        check("rst_im",      32'(do_im),      32'd0);
        check("rst_idx",     32'(do_idx),     32'd0);
        check("rst_sym_end", 32'(do_sym_end), 32'd0);
        @(posedge clk); #1;

        // T1: QPSK 1,0
        mode = 2'd1;
        push_exp(12'h2D4, 12'hD2C);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        drain("t1_drain");

        // T2: 16QAM 1,0,0,1
        mode = 2'd2;
        push_exp(12'h3CC, 12'hEBC);
        send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
        drain("t2_drain");

        // T3: 64QAM 1,0,0,0,1,1 with 2-cycle gaps
        mode = 2'd3;
        push_exp(12'h452, 12'hE26);
        send_bit(1'b1, 2); send_bit(1'b0, 2); send_bit(1'b0, 2);
        send_bit(1'b0, 2); send_bit(1'b1, 2); send_bit(1'b1, 2);
        drain("t3_drain");

        // T4: BPSK 96 random bits over two symbols, index restarted
        do_reset();
        mode = 2'd0;
        for (int i = 0; i < 96; i++) begin
            logic b;
            b = 1'($urandom_range(0, 1));
            push_exp(b ? 12'h400 : 12'hC00, 12'h000);
            send_bit(b, (i % 7 == 3) ? 1 : 0);
        end
        drain("t4_drain");
        check("t4_idx_wrapped", 32'(exp_idx), 32'd0);

        // T5: mode change mid-group is ignored
        do_reset();
        mode = 2'd2;
        send_bit(1'b1, 0); send_bit(1'b1, 0);
        mode = 2'd1;
        push_exp(12'h144, 12'hEBC);
        send_bit(1'b0, 0); send_bit(1'b1, 0);
        push_exp(12'hD2C, 12'h2D4);
        send_bit(1'b0, 0); send_bit(1'b1, 0);
        drain("t5_drain");

        // T6: reset mid-group discards partial bits
        mode = 2'd3;
        send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
        do_reset();
        push_exp(12'hF62, 12'h09E);
        send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
        send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
        drain("t6_drain");

        // T7: reset on the completing-bit edge suppresses the sample
        mode = 2'd1;
        send_bit(1'b1, 0);
        di     = 1'b1;
        di_vld = 1'b1;
        rst    = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        di_vld  = 1'b0;
        exp_idx = 0;
        drain("t7_no_sample");
        push_exp(12'h2D4, 12'h2D4);
        send_bit(1'b1, 0); send_bit(1'b1, 0);
        drain("t7_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
